// File: rtl/ula_pkg.sv
// -----------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the multi-beat ULA sequencer and anything that models
// or drives the external 8-bit ULA slice.
//   - op_t            : 2-bit operation code
//   - OP_AND/OR/XOR/ADD: operation encodings (also used on the slice bus)
//   - state_t         : sequencer FSM states (IDLE, EXEC, DONE)
// -----------------------------------------------------------------------------
package ula_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND = 2'b00;
    localparam op_t OP_OR  = 2'b01;
    localparam op_t OP_XOR = 2'b10;
    localparam op_t OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : ula_pkg

// File: rtl/ula_sequenciador.sv
// -----------------------------------------------------------------------------
// ula_sequenciador
// Executes WIDTH-bit AND/OR/XOR/ADD operations on an external, combinational
// SLICE-bit ULA slice, one slice per clock, least-significant slice first.
// Carry is chained between beats for ADD only.
//
// Ports
//   CLK, RST_N           : clock, synchronous active-low reset
//   IN_VALID/IN_READY    : operation request handshake (A, B, OP)
//   ULA_EN/A/B/OP/CIN    : drive of the external slice (all zero outside EXEC)
//   ULA_RES, ULA_COUT    : combinational slice result and carry-out
//   OUT_VALID/OUT_READY  : result handshake (RESULTADO, CARRY)
//   ZERO, NEGATIVO       : result flags, present only with ULA_SEQ_FLAGS_EN
//
// Optional build macro: ULA_SEQ_FLAGS_EN adds the ZERO/NEGATIVO outputs.
// -----------------------------------------------------------------------------
module ula_sequenciador
    import ula_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       OP,
    output logic             ULA_EN,
    output logic [SLICE-1:0] ULA_A,
    output logic [SLICE-1:0] ULA_B,
    output logic [1:0]       ULA_OP,
    output logic             ULA_CIN,
    input  logic [SLICE-1:0] ULA_RES,
    input  logic             ULA_COUT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
`ifdef ULA_SEQ_FLAGS_EN
    output logic             ZERO,
    output logic             NEGATIVO,
`endif
    output logic [WIDTH-1:0] RESULTADO,
    output logic             CARRY
);

    localparam int BEATS = WIDTH / SLICE;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_width
            $error("ula_sequenciador: WIDTH must be an integer multiple of SLICE");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    op_t              op_q, op_d;
    logic             carry_q, carry_d;   // inter-beat carry chain
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;     // final carry presented on CARRY
`ifdef ULA_SEQ_FLAGS_EN
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ULA_SEQ_FLAGS_EN
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
`ifdef ULA_SEQ_FLAGS_EN
            zero_q  <= zero_d;
            neg_q   <= neg_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        carry_d   = carry_q;
        res_d     = res_q;
        cout_d    = cout_q;
`ifdef ULA_SEQ_FLAGS_EN
        zero_d    = zero_q;
        neg_d     = neg_q;
`endif
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        ULA_EN    = 1'b0;
        ULA_A     = '0;
        ULA_B     = '0;
        ULA_OP    = 2'b00;
        ULA_CIN   = 1'b0;

        case (state_q)
            IDLE: begin
                // Reset dominates in the register, but the ready output must
                // also read low while reset is held.
                IN_READY = RST_N;
                if (IN_VALID) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = OP;
                    carry_d = 1'b0;
                    beat_d  = '0;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                ULA_EN  = 1'b1;
                ULA_OP  = op_q;
                ULA_A   = a_q[int'(beat_q) * SLICE +: SLICE];
                ULA_B   = b_q[int'(beat_q) * SLICE +: SLICE];
                ULA_CIN = (op_q == OP_ADD) ? carry_q : 1'b0;

                res_d[int'(beat_q) * SLICE +: SLICE] = ULA_RES;
                // Logic ops never propagate the slice carry-out.
                carry_d = (op_q == OP_ADD) ? ULA_COUT : 1'b0;

                if (beat_q == LAST_BEAT) begin
                    cout_d  = carry_d;
`ifdef ULA_SEQ_FLAGS_EN
                    zero_d  = (res_d == '0);
                    neg_d   = res_d[WIDTH-1];
`endif
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end

            DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign RESULTADO = res_q;
    assign CARRY     = cout_q;
`ifdef ULA_SEQ_FLAGS_EN
    assign ZERO      = zero_q;
    assign NEGATIVO  = neg_q;
`endif

endmodule : ula_sequenciador

// File: doc/ula_sequenciador.md
Name: ula_sequenciador

Overview:
Multi-beat controller that executes WIDTH-bit ALU operations on a narrow combinational SLICE-bit ALU slice, one slice per cycle, least-significant slice first.
- Accepts an operation through a valid/ready input handshake.
- Sequences the external slice and chains carry between beats for ADD.
- Assembles the result and returns it through a valid/ready output handshake.
- Sits between the instruction front end and the shared 8-bit ULA slice, extending the AND/OR/XOR datapath to 16-bit operands.

Parameters:
- WIDTH, 16: operand/result width; must be an integer multiple of SLICE.
- SLICE, 8: width of the external ALU slice.
- BEATS, WIDTH/SLICE: derived, not overridable; number of execute cycles.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset: synchronous, active-low.
- IN_VALID  in  1  operation request.
- IN_READY  out  1  controller can accept.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- OP  in  2  operation code: 00 AND, 01 OR, 10 XOR, 11 ADD.
- ULA_EN  out  1  slice active this cycle.
- ULA_A  out  SLICE  slice operand A.
- ULA_B  out  SLICE  slice operand B.
- ULA_OP  out  2  slice operation code.
- ULA_CIN  out  1  slice carry-in.
- ULA_RES  in  SLICE  slice result, combinational from the ULA_* outputs.
- ULA_COUT  in  1  slice carry-out.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  consumer accepts.
- RESULTADO  out  WIDTH  assembled result.
- CARRY  out  1  final carry-out; ADD only.

Behaviour:
- Clocking and reset: one clock, CLK. RST_N is synchronous and active-low, sampled at the CLK rising edge.
- Reset values: state=IDLE, beat counter=0, carry register=0, RESULTADO=0, CARRY=0, OUT_VALID=0. IN_READY=0 while RST_N=0.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY: latch A, B and OP; clear the carry register and beat counter; go to EXEC.
- EXEC:
  - Outputs: IN_READY=0, ULA_EN=1, ULA_OP=latched OP.
  - Slice operands: ULA_A/ULA_B = latched A/B bits [beat*SLICE +: SLICE].
  - ULA_CIN = carry register when OP=ADD, else 0.
  - Each cycle: capture ULA_RES into the result register at the same slice position. Carry register <= ULA_COUT if OP=ADD, else 0.
  - beat==BEATS-1: go to DONE and load CARRY from the final carry; otherwise increment beat.
- DONE:
  - OUT_VALID=1; RESULTADO and CARRY held stable.
  - On OUT_READY: OUT_VALID drops next cycle; go to IDLE.
- Slice outputs outside EXEC: ULA_EN=0 and ULA_A/ULA_B/ULA_OP/ULA_CIN=0.
- Latency: request accepted at edge T gives OUT_VALID=1 from cycle T+BEATS. Default: 2 EXEC cycles. Minimum issue interval: BEATS+2 cycles.
- Boundary conditions:
  - IN_VALID while in EXEC or DONE is not accepted; no operand is latched. The requester must hold the request.
  - OUT_READY held low: stay in DONE indefinitely; outputs unchanged.
  - OUT_READY high before OUT_VALID: no effect.
  - RST_N low mid-EXEC or in DONE: the operation is abandoned with no OUT_VALID; all reset values are applied at that edge.
  - ADD overflow wraps modulo 2^WIDTH; the carry-out appears on CARRY.
  - Logic ops always return CARRY=0, independent of ULA_COUT.
- Elaboration: WIDTH % SLICE != 0 raises an error.

Optional Feature:
- Macro: ULA_SEQ_FLAGS_EN.
- Defined: adds outputs ZERO (1 bit, result==0) and NEGATIVO (1 bit, RESULTADO[WIDTH-1]).
  - Both are registered with RESULTADO on the final EXEC beat.
  - Both reset to 0 and are held through DONE.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ula_pkg:
  - OP encoding constants OP_AND/OP_OR/OP_XOR/OP_ADD.
  - 2-bit op typedef.
  - FSM state typedef (IDLE/EXEC/DONE).
- No sub-module inside the controller: the slice is external and shared.
- The bench provides a behavioural slice model built from the same package constants.

Test Plan:
- OP=AND, A=0xF0F0, B=0xFF00 -> after 2 EXEC beats, RESULTADO=0xF000, CARRY=0, OUT_VALID at T+2.
- OP=ADD, A=0x00FF, B=0x0001 -> ULA_CIN=1 on beat 1, RESULTADO=0x0100, CARRY=0.
- OP=ADD, A=0xFFFF, B=0x0001 -> RESULTADO=0x0000, CARRY=1 (with flags: ZERO=1, NEGATIVO=0).
- OP=XOR, A=0xAAAA, B=0xFFFF with OUT_READY low for 5 cycles -> OUT_VALID and RESULTADO=0x5555 held stable all 5 cycles; IDLE one cycle after OUT_READY.
- IN_VALID with new operands asserted during EXEC and DONE -> IN_READY=0 throughout, result unchanged; the held request is accepted only in the following IDLE cycle.
- RST_N pulled low for 1 cycle during EXEC beat 0 -> no OUT_VALID, RESULTADO=0, IDLE with IN_READY=1 the cycle after RST_N returns high.
